i2c_mem_arbiter: RTL and testbench

- Shares the single I2C register memory (`I2C_Memory_Bus` signal set) between two requesters:
  - port 0: I2C slave data path, after synchronisation into `clk`;
  - port 1: APB-side host access.
- Each request is serialised into one memory strobe cycle.
- Read data is captured after a fixed memory latency, and per-port completion is signalled.
- Sits between both requesters and the memory, in the `clk` domain.

---
 rtl/i2c_mem_arbiter.sv | 136 +++++++++++++
 tb/tb_i2c_mem_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_mem_arbiter.sv
// Purpose: arbitrate the single I2C register memory between the synchronised slave path (port 0) and APB host (port 1).
// Latency: write = gnt T+1, done T+2; read = gnt T+1, done T+2+RD_LAT; one transfer in flight at a time.
// Backpressure: req is level and sampled only in IDLE; a losing or busy-blocked requester simply waits for gnt.
// Build option: define I2C_ARB_FIXED_PRIO_EN for fixed port-0 priority instead of round-robin.
module i2c_mem_arbiter #(
    parameter int AW     = 8,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_gnt,
    output logic          p0_done,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_gnt,
    output logic          p1_done,
    output logic [DW-1:0] p1_rdata,
    output logic          mem_ce,
    output logic          mem_wren,
    output logic          mem_rden,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    // Counter is loaded with RD_LAT-1 so the last WAIT cycle is the one where mem_rdata is valid.
    localparam logic [1:0] LAT_LOAD = 2'(RD_LAT - 1);

    state_t     state;
    logic       win_id;
    logic       cur_we;
    logic [1:0] lat_cnt;
    logic       any_req;
    logic       pick;
`ifndef I2C_ARB_FIXED_PRIO_EN
    logic       last;
`endif

    // Choose the winner among current requesters; a lone requester always wins.
    always_comb begin
        any_req = p0_req | p1_req;
`ifdef I2C_ARB_FIXED_PRIO_EN
        pick = !p0_req;
`else
        pick = (p0_req && p1_req) ? ~last : p1_req;
`endif
    end

    // Transfer sequencer: latch winner, strobe memory once, count read latency, pulse completion.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            win_id    <= 1'b0;
            cur_we    <= 1'b0;
            lat_cnt   <= 2'd0;
`ifndef I2C_ARB_FIXED_PRIO_EN
            last      <= 1'b1;
`endif
            p0_gnt    <= 1'b0;
            p1_gnt    <= 1'b0;
            p0_done   <= 1'b0;
            p1_done   <= 1'b0;
            p0_rdata  <= '0;
            p1_rdata  <= '0;
            mem_ce    <= 1'b0;
            mem_wren  <= 1'b0;
            mem_rden  <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            // Pulses and strobes default low; only the state that owns them raises them.
            p0_gnt   <= 1'b0;
            p1_gnt   <= 1'b0;
            p0_done  <= 1'b0;
            p1_done  <= 1'b0;
            mem_ce   <= 1'b0;
            mem_wren <= 1'b0;
            mem_rden <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        win_id    <= pick;
`ifndef I2C_ARB_FIXED_PRIO_EN
                        last      <= pick;
`endif
                        cur_we    <= pick ? p1_we : p0_we;
                        mem_addr  <= pick ? p1_addr : p0_addr;
                        mem_wdata <= pick ? p1_wdata : p0_wdata;
                        mem_ce    <= 1'b1;
                        mem_wren  <= pick ? p1_we : p0_we;
                        mem_rden  <= pick ? !p1_we : !p0_we;
                        p0_gnt    <= !pick;
                        p1_gnt    <= pick;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cur_we) begin
                        p0_done <= !win_id;
                        p1_done <= win_id;
                        state   <= DONE;
                    end else begin
                        lat_cnt <= LAT_LOAD;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (lat_cnt == 2'd0) begin
                        if (win_id) p1_rdata <= mem_rdata;
                        else        p0_rdata <= mem_rdata;
                        p0_done <= !win_id;
                        p1_done <= win_id;
                        state   <= DONE;
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_mem_arbiter.sv
// Directed bench for i2c_mem_arbiter with a behavioural memory of RD_LAT read latency.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_i2c_mem_arbiter;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int RD_LAT = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          p0_req, p0_we, p1_req, p1_we;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [DW-1:0] p0_wdata, p1_wdata;
    logic          p0_gnt, p0_done, p1_gnt, p1_done;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic          mem_ce, mem_wren, mem_rden;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    i2c_mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_rdata(p1_rdata),
        .mem_ce(mem_ce), .mem_wren(mem_wren), .mem_rden(mem_rden),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Behavioural memory: read data appears RD_LAT cycles after the strobe cycle, 0xEE otherwise.
    logic [DW-1:0] mem [256];
    logic [DW-1:0] pipe [RD_LAT];
    assign mem_rdata = pipe[RD_LAT-1];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        for (int i = 0; i < RD_LAT; i++) pipe[i] = 8'hEE;
    end

    always @(posedge clk) begin
        if (mem_ce && mem_wren) mem[mem_addr] <= mem_wdata;
        pipe[0] <= (mem_ce && mem_rden) ? mem[mem_addr] : 8'hEE;
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_strobes"}, {p0_gnt, p0_done, p1_gnt, p1_done, mem_ce, mem_wren, mem_rden}, 0);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_wdata"}, mem_wdata, 0);
        check({tag, "_rdata"}, {p0_rdata, p1_rdata}, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Single transfer from an idle arbiter with only this port requesting.
    task automatic xfer(input int port, input logic we, input logic [7:0] addr,
                        input logic [7:0] wdata, input logic [7:0] exp_rd);
        int n;
        int rd_strobes;
        logic [7:0] other_rd;
        @(negedge clk);
        other_rd = (port == 0) ? p1_rdata : p0_rdata;
        if (port == 0) begin
            p0_req = 1; p0_we = we; p0_addr = addr; p0_wdata = wdata;
        end else begin
            p1_req = 1; p1_we = we; p1_addr = addr; p1_wdata = wdata;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!((port == 0) ? p0_gnt : p1_gnt) && n < 20);
        check("gnt_latency", n, 1);
        check("strobe", {mem_ce, mem_wren, mem_rden}, {1'b1, we, !we});
        check("strobe_addr", mem_addr, addr);
        if (we) check("strobe_wdata", mem_wdata, wdata);
        p0_req = 0; p1_req = 0;
        n = 0;
        rd_strobes = 0;
        do begin
            @(negedge clk);
            n++;
            if (mem_ce) rd_strobes++;
        end while (!((port == 0) ? p0_done : p1_done) && n < 20);
        check("done_latency", n, we ? 1 : RD_LAT + 1);
        check("extra_strobes", rd_strobes, 0);
        check("addr_held", mem_addr, addr);
        if (!we) check("rdata", (port == 0) ? p0_rdata : p1_rdata, exp_rd);
        check("other_rdata_held", (port == 0) ? p1_rdata : p0_rdata, other_rd);
        @(negedge clk);
        check("done_pulse_one_cycle", {p0_done, p1_done}, 0);
    endtask

    initial begin
        int order [4];
        int gtime [4];
        int ng, n, cnt;
        reset = 1'b1;
        p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
        p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;

        // Reset state.
        do_reset();
        check_reset_outputs("reset");

        // Both ports hold write requests continuously.
        @(negedge clk);
        p0_req = 1; p0_we = 1; p0_addr = 8'h20; p0_wdata = 8'h11;
        p1_req = 1; p1_we = 1; p1_addr = 8'h30; p1_wdata = 8'h22;
        ng = 0; n = 0;
        while (ng < 4 && n < 40) begin
            @(negedge clk);
            n++;
            if (p0_gnt && p1_gnt) check("dual_gnt", 1, 0);
            if (p0_gnt || p1_gnt) begin
                order[ng] = p1_gnt ? 1 : 0;
                gtime[ng] = n;
                ng++;
            end
        end
        p0_req = 0; p1_req = 0;
        check("grant_count", ng, 4);
`ifdef I2C_ARB_FIXED_PRIO_EN
        check("grant_order", {order[0][3:0], order[1][3:0], order[2][3:0], order[3][3:0]}, 16'h0000);
`else
        check("grant_order", {order[0][3:0], order[1][3:0], order[2][3:0], order[3][3:0]}, 16'h0101);
`endif
        check("grant_spacing", {gtime[1] - gtime[0], gtime[2] - gtime[1], gtime[3] - gtime[2]}, {32'd3, 32'd3, 32'd3});
        repeat (3) @(negedge clk);

        // Same address from both ports: port 0 write wins the tie, port 1 read sees the new data.
        do_reset();
        p0_req = 1; p0_we = 1; p0_addr = 8'h50; p0_wdata = 8'h3C;
        p1_req = 1; p1_we = 0; p1_addr = 8'h50; p1_wdata = 8'h00;
        n = 0;
        do begin @(negedge clk); n++; end while (!p0_gnt && n < 20);
        check("same_addr_p0_first", {p0_gnt, p1_gnt}, 2'b10);
        p0_req = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (!p1_gnt && n < 20);
        check("same_addr_p1_gnt", p1_gnt, 1);
        p1_req = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (!p1_done && n < 20);
        check("same_addr_read", p1_rdata, 8'h3C);
        @(negedge clk);

        // Port 0 write then read back; port 1 read leaves port 0 rdata alone.
        xfer(0, 1'b1, 8'h10, 8'hA5, 8'h00);
        xfer(0, 1'b0, 8'h10, 8'h00, 8'hA5);
        xfer(1, 1'b1, 8'h11, 8'h5A, 8'h00);
        xfer(1, 1'b0, 8'h11, 8'h00, 8'h5A);
        check("p0_rdata_kept", p0_rdata, 8'hA5);

        // Port 0 pulses req for one cycle while port 1 is busy: never granted, never accessed.
        @(negedge clk);
        p1_req = 1; p1_we = 1; p1_addr = 8'h60; p1_wdata = 8'h77;
        @(negedge clk);
        check("busy_p1_gnt", p1_gnt, 1);
        p1_req = 0;
        p0_req = 1; p0_we = 1; p0_addr = 8'h61; p0_wdata = 8'h99;
        @(negedge clk);
        p0_req = 0;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (p0_gnt || mem_ce) cnt++;
        end
        check("withdrawn_req", cnt, 0);
        check("withdrawn_mem", mem[8'h61], 8'h00);

        // Reset during the read latency wait: no completion, then normal service.
        @(negedge clk);
        p1_req = 1; p1_we = 0; p1_addr = 8'h10;
        n = 0;
        do begin @(negedge clk); n++; end while (!p1_gnt && n < 20);
        p1_req = 0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check_reset_outputs("mid_wait_reset");
        cnt = 0;
        for (int i = 0; i < RD_LAT + 4; i++) begin
            @(negedge clk);
            if (p0_done || p1_done || mem_ce) cnt++;
        end
        check("no_done_after_reset", cnt, 0);
        xfer(1, 1'b0, 8'h10, 8'h00, 8'hA5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
